// File: rtl/comparator_self_test_if.sv
// Bundle between the comparator self-test engine and its environment:
// operand drive, result flags, start request and sweep status/report.
interface comparator_self_test_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
);
  logic             start;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [2:0]       fail_flags;

  // Environment side: issues start, hosts the comparator, reads the report.
  modport master (
    output start, cmp_eq, cmp_gt, cmp_lt,
    input  cmp_a, cmp_b, busy, done, pass, err_count,
    input  fail_valid, fail_a, fail_b, fail_flags
  );

  // Self-test engine side.
  modport slave (
    input  start, cmp_eq, cmp_gt, cmp_lt,
    output cmp_a, cmp_b, busy, done, pass, err_count,
    output fail_valid, fail_a, fail_b, fail_flags
  );
endinterface

// File: rtl/comparator_self_test.sv
// Built-in self-test sweep for a magnitude comparator: drives every {A,B} pair,
// waits SETTLE cycles, checks the flags; done rises 2^(2*WIDTH)*(SETTLE+1) cycles after start.
module comparator_self_test #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1,   // legal range 1..15
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  comparator_self_test_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2*WIDTH-1:0] VEC_ONE     = (2*WIDTH)'(1);
  localparam logic [ERR_W-1:0]   ERR_ONE     = ERR_W'(1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [2:0]       ff_q, ff_d;

  logic [2:0] exp_flags;
  logic [2:0] act_flags;
  logic       mismatch;
  logic       last_vec;

  assign exp_flags = (a_q == b_q) ? 3'b100 : ((a_q > b_q) ? 3'b010 : 3'b001);
  assign act_flags = {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt};
  assign mismatch  = (act_flags != exp_flags);
  assign last_vec  = (a_q == '1) && (b_q == '1);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    ff_d     = ff_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_SETTLE;
          settle_d = '0;
          a_d      = '0;
          b_d      = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fv_d     = 1'b0;
          fa_d     = '0;
          fb_d     = '0;
          ff_d     = '0;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_CHECK;
        else                         settle_d = settle_q + 4'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_ONE;
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
            ff_d = act_flags;
          end
        end
        // pass reflects the count including this final vector's result
        if (last_vec) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          {a_d, b_d} = {a_q, b_q} + VEC_ONE;
          settle_d   = '0;
          state_d    = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      ff_q     <= ff_d;
    end
  end

  assign bus.cmp_a      = a_q;
  assign bus.cmp_b      = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_a     = fa_q;
  assign bus.fail_b     = fb_q;
  assign bus.fail_flags = ff_q;

endmodule
